// File: rtl/rr_port_arbiter.sv
// Packet-level round-robin arbiter sharing one output port among NUM_REQ requesters.
// Holds each grant until last beat, abort or stall timeout, then hands over back-to-back.
module rr_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    input  logic                       out_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       beat,
    output logic                       timeout_err,
    output logic                       abort_err,
    output logic [CNT_W-1:0]           pkt_count
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int STALL_W = 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]         state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [ID_W-1:0]    gid_q,    gid_d;
    logic [ID_W-1:0]    ptr_q,    ptr_d;
    logic [STALL_W-1:0] stall_q,  stall_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               tout_q,   tout_d;
    logic               abort_q,  abort_d;

    logic               granted;
    logic [NUM_REQ-1:0] g_onehot;
    logic [ID_W-1:0]    g_next;
    logic [STALL_W-1:0] stall_inc;
    logic               rel_done;
    logic               rel_abort;
    logic               rel_tout;
    logic               release_now;
    logic [ID_W-1:0]    arb_ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;

    assign granted   = (state_q == S_GRANT);
    assign g_onehot  = NUM_REQ'(1) << gid_q;
    assign g_next    = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
    assign stall_inc = stall_q + STALL_W'(1);

    assign beat = granted & req[gid_q] & out_ready;

    // Abort wins over timeout: a dropped request can never also be counted as a stall.
    assign rel_done    = beat & last[gid_q];
    assign rel_abort   = granted & ~req[gid_q];
    assign rel_tout    = granted & ~rel_abort & ~beat & (stall_inc == STALL_W'(MAX_STALL));
    assign release_now = rel_done | rel_abort | rel_tout;

    // On release the outgoing grantee is masked so it can only return via IDLE.
    assign arb_ptr = release_now ? g_next : ptr_q;
    assign arb_req = !granted ? req : (release_now ? (req & ~g_onehot) : '0);

    always_comb begin : arbiter
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_valid = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(arb_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_valid && arb_req[idx]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        abort_d = 1'b0;

        if (granted) begin
            if (release_now) begin
                ptr_d   = g_next;
                stall_d = '0;
                tout_d  = rel_tout;
                abort_d = rel_abort;
                if (rel_done) cnt_d = cnt_q + CNT_W'(1);
            end else if (beat) begin
                stall_d = '0;
            end else begin
                stall_d = stall_inc;
            end
        end

        if (!granted || release_now) begin
            if (win_valid) begin
                state_d = S_GRANT;
                grant_d = NUM_REQ'(1) << win_id;
                gid_d   = win_id;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                gid_d   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            abort_q <= abort_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign busy        = granted;
    assign timeout_err = tout_q;
    assign abort_err   = abort_q;
    assign pkt_count   = cnt_q;

endmodule
